// File: rtl/mux2_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux2_arb_pkg
// Shared definitions for the two-source packet arbiter/mux:
//   state_e    : arbiter FSM states (IDLE, HOLD_A, HOLD_B)
//   SEL_A/SEL_B: 2:1 mux select encoding, also used to record the last grant
//   WIDTH_DEF  : default payload width
// -----------------------------------------------------------------------------
package mux2_arb_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_e;

endpackage : mux2_arb_pkg

// File: rtl/rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-requester round-robin grant.
// Ports:
//   req_a, req_b : request (valid) from each source
//   last_grant   : source granted on the most recent transfer (SEL_A / SEL_B)
//   grant_a      : grant to source A
//   grant_b      : grant to source B
// A lone request is always granted; on contention the source that did not
// win last time is granted. Never grants both.
// -----------------------------------------------------------------------------
module rr_grant2
    import mux2_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_a,
    output logic grant_b
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (req_a && req_b) begin
            grant_a = (last_grant == SEL_B);
            grant_b = (last_grant == SEL_A);
        end else begin
            grant_a = req_a;
            grant_b = req_b;
        end
    end

endmodule : rr_grant2

// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
// Two-source valid/ready arbiter feeding a single registered output slot.
// Beats accepted in cycle n appear on y_* in cycle n+1; the slot drains and
// refills in the same cycle, so a steady stream runs at one beat per clock.
//
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   a_data/a_valid/a_last    : source A payload, valid, end-of-packet
//   a_ready                  : A beat accepted this cycle
//   b_data/b_valid/b_last    : source B, as for A
//   b_ready                  : B beat accepted this cycle
//   y_data/y_valid/y_last    : registered output beat
//   y_ready                  : downstream accepts the held beat
//   sel                      : source of the held beat (SEL_A / SEL_B)
//
// Build option MUX2_ARB_PACKET_LOCK_EN: once a non-last beat is accepted from
// a source, the grant stays locked on that source until its last beat is
// accepted. Without it, arbitration is per beat and *_last only passes through.
// -----------------------------------------------------------------------------
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel
);

    state_e           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] y_data_q,     y_data_d;
    logic             y_valid_q,    y_valid_d;
    logic             y_last_q,     y_last_d;
    logic             sel_q,        sel_d;

    logic rr_grant_a, rr_grant_b;
    logic grant_a, grant_b;
    logic slot_free;
    logic a_xfer, b_xfer;

    rr_grant2 u_rr_grant2 (
        .req_a      (a_valid),
        .req_b      (b_valid),
        .last_grant (last_grant_q),
        .grant_a    (rr_grant_a),
        .grant_b    (rr_grant_b)
    );

    // A locked state overrides round-robin, even while the locked source idles,
    // so the other source cannot slip a beat into the middle of a packet.
    always_comb begin
        grant_a = rr_grant_a;
        grant_b = rr_grant_b;
        case (state_q)
            HOLD_A: begin
                grant_a = 1'b1;
                grant_b = 1'b0;
            end
            HOLD_B: begin
                grant_a = 1'b0;
                grant_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Slot is free when empty or being drained this cycle.
    assign slot_free = !y_valid_q || y_ready;
    assign a_ready   = grant_a && slot_free;
    assign b_ready   = grant_b && slot_free;
    assign a_xfer    = a_valid && a_ready;
    assign b_xfer    = b_valid && b_ready;

    always_comb begin
        y_data_d     = y_data_q;
        y_valid_d    = y_valid_q;
        y_last_d     = y_last_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        state_d      = state_q;

        if (a_xfer) begin
            y_data_d     = a_data;
            y_last_d     = a_last;
            y_valid_d    = 1'b1;
            sel_d        = SEL_A;
            last_grant_d = SEL_A;
        end else if (b_xfer) begin
            y_data_d     = b_data;
            y_last_d     = b_last;
            y_valid_d    = 1'b1;
            sel_d        = SEL_B;
            last_grant_d = SEL_B;
        end else if (y_ready) begin
            y_valid_d    = 1'b0;
        end

`ifdef MUX2_ARB_PACKET_LOCK_EN
        if (a_xfer) begin
            state_d = a_last ? IDLE : HOLD_A;
        end else if (b_xfer) begin
            state_d = b_last ? IDLE : HOLD_B;
        end
`else
        state_d = IDLE;
`endif
    end

    // Output register / control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_B;
            y_data_q     <= '0;
            y_valid_q    <= 1'b0;
            y_last_q     <= 1'b0;
            sel_q        <= SEL_A;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            y_data_q     <= y_data_d;
            y_valid_q    <= y_valid_d;
            y_last_q     <= y_last_d;
            sel_q        <= sel_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;
    assign sel     = sel_q;

endmodule : mux2_arbiter

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
// Directed and randomized bench for mux2_arbiter. A behavioural model of the
// arbitration rules tracks the expected output slot and ready signals; the
// directed sections also check emitted beat order against fixed sequences.
// Honours MUX2_ARB_PACKET_LOCK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic         a_ready, b_ready;
    logic [W-1:0] y_data;
    logic         y_valid, y_last, sel;
    logic         y_ready = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Model state: contents of the output slot, last winner, packet lock owner.
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_last;
    bit           m_sel;
    int           m_last_src;   // 0 = A, 1 = B
    int           m_lock;       // -1 = none, 0 = A, 1 = B
    bit           acc_a, acc_b; // accepts in the cycle just run

    logic [W:0]   emitted[$];   // {sel, data} of beats seen leaving

    mux2_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_last  (y_last),
        .y_ready (y_ready),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        m_sel      = 1'b0;
        m_last_src = 1;
        m_lock     = -1;
        acc_a      = 1'b0;
        acc_b      = 1'b0;
        emitted.delete();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_last  = 1'b0;
        b_last  = 1'b0;
        y_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: inputs are already driven. Check at the falling edge, advance
    // the model, then return 1 time unit after the rising edge.
    task automatic cycle();
        bit slot, ga, gb;
        @(negedge clk);
        chk1("y_valid", y_valid, m_valid);
        if (m_valid) begin
            chk8("y_data", y_data, m_data);
            chk1("y_last", y_last, m_last);
            chk1("sel", sel, m_sel);
        end

        slot = !m_valid || y_ready;
        if (m_lock == 0) begin
            ga = 1'b1; gb = 1'b0;
        end else if (m_lock == 1) begin
            ga = 1'b0; gb = 1'b1;
        end else if (a_valid && b_valid) begin
            ga = (m_last_src == 1);
            gb = (m_last_src == 0);
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
        chk1("a_ready", a_ready, ga && slot);
        chk1("b_ready", b_ready, gb && slot);
        chk1("ready_excl", a_ready && b_ready, 1'b0);

        if (y_valid && y_ready) emitted.push_back({sel, y_data});

        acc_a = a_valid && ga && slot;
        acc_b = b_valid && gb && slot;
        if (acc_a) begin
            m_valid = 1'b1; m_data = a_data; m_last = a_last; m_sel = 1'b0;
            m_last_src = 0;
        end else if (acc_b) begin
            m_valid = 1'b1; m_data = b_data; m_last = b_last; m_sel = 1'b1;
            m_last_src = 1;
        end else if (y_ready) begin
            m_valid = 1'b0;
        end
`ifdef MUX2_ARB_PACKET_LOCK_EN
        if (acc_a) m_lock = a_last ? -1 : 0;
        else if (acc_b) m_lock = b_last ? -1 : 1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ai, bi;
        model_reset();

        // Reset state
        do_reset();
        chk1("rst_y_valid", y_valid, 1'b0);
        chk1("rst_y_last", y_last, 1'b0);
        chk1("rst_sel", sel, 1'b0);
        chk8("rst_y_data", y_data, 8'h00);

        // Single beat from A: ready in cycle 0, output in cycle 1
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; y_ready = 1'b1;
        cycle();
        chk1("single_acc_a", acc_a, 1'b1);
        a_valid = 1'b0;
        cycle();
        chki("single_emit_cnt", emitted.size(), 1);
        if (emitted.size() >= 1) chki("single_emit", int'(emitted[0]), int'({1'b0, 8'h11}));
        cycle();
        chk1("drain_y_valid", y_valid, 1'b0);

        // Both valid continuously: A0,B0,A1,B1 with no bubbles
        do_reset();
        ai = 0; bi = 0;
        y_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b1; b_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'hA0 + W'(ai);
            b_data = 8'hB0 + W'(bi);
            cycle();
            if (acc_a) ai++;
            if (acc_b) bi++;
        end
        chki("rr_emit_cnt", emitted.size(), 5);
        if (emitted.size() >= 4) begin
            chki("rr_0", int'(emitted[0]), int'({1'b0, 8'hA0}));
            chki("rr_1", int'(emitted[1]), int'({1'b1, 8'hB0}));
            chki("rr_2", int'(emitted[2]), int'({1'b0, 8'hA1}));
            chki("rr_3", int'(emitted[3]), int'({1'b1, 8'hB1}));
        end

        // Stall: 0x5C held for 4 cycles with both sources waiting
        do_reset();
        a_valid = 1'b1; a_data = 8'h5C; a_last = 1'b1; y_ready = 1'b0;
        cycle();
        a_data = 8'h77; b_valid = 1'b1; b_data = 8'h88; b_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk8("stall_data", y_data, 8'h5C);
            chk1("stall_acc", acc_a || acc_b, 1'b0);
        end
        y_ready = 1'b1;
        cycle();

        // Three-beat A packet against a continuously valid B
        do_reset();
        ai = 0; bi = 0;
        y_ready = 1'b1; b_valid = 1'b1; b_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_valid = (ai < 3);
            a_data  = 8'h30 + W'(ai);
            a_last  = (ai == 2);
            b_data  = 8'h40 + W'(bi);
            cycle();
            if (acc_a) ai++;
            if (acc_b) bi++;
        end
        chk1("pkt_enough", emitted.size() >= 4, 1'b1);
        if (emitted.size() >= 4) begin
`ifdef MUX2_ARB_PACKET_LOCK_EN
            chki("pkt_order", int'({emitted[0][W], emitted[1][W], emitted[2][W], emitted[3][W]}), 'b0001);
            chk8("pkt_beat1", emitted[1][W-1:0], 8'h31);
`else
            chki("pkt_order", int'({emitted[0][W], emitted[1][W], emitted[2][W], emitted[3][W]}), 'b0101);
            chk8("pkt_beat1", emitted[1][W-1:0], 8'h40);
`endif
        end

        // Reset in the middle of a held B packet beat
        do_reset();
        b_valid = 1'b1; b_data = 8'h66; b_last = 1'b0; y_ready = 1'b0;
        cycle();
        a_valid = 1'b1; a_data = 8'h01; a_last = 1'b1;
        cycle();
        reset = 1'b1;
        #1;
        chk1("async_rst_valid", y_valid, 1'b0);
        chk8("async_rst_data", y_data, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_valid = 1'b1; a_data = 8'h01; b_valid = 1'b1; b_data = 8'h02; b_last = 1'b1;
        y_ready = 1'b1;
        cycle();
        chk1("post_rst_a_wins", acc_a, 1'b1);
        cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();
        cycle();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data  = W'($urandom);
            b_data  = W'($urandom);
            a_last  = ($urandom_range(0, 2) == 0);
            b_last  = ($urandom_range(0, 2) == 0);
            y_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_mux2_arbiter

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every data port.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 a_data  input  WIDTH  SHALL be the source A payload.
REQ-005 a_valid  input  1  SHALL flag that a_data is offered.
REQ-006 a_last  input  1  SHALL mark the final beat of an A packet.
REQ-007 a_ready  output  1  SHALL flag that an A beat is accepted this cycle.
REQ-008 b_data, b_valid, b_last, b_ready SHALL mirror REQ-004..007 for source B.
REQ-009 y_data  output  WIDTH  SHALL be the registered output payload.
REQ-010 y_valid  output  1  SHALL flag that y_data holds a beat.
REQ-011 y_last  output  1  SHALL be the registered last flag of the held beat.
REQ-012 y_ready  input  1  SHALL flag that the downstream consumer accepts the beat.
REQ-013 sel  output  1  SHALL give the source of the held beat: 0 = A, 1 = B (2:1 mux select encoding).

Function
REQ-014 Slot free SHALL mean (!y_valid || y_ready); a beat SHALL transfer on an input only while its valid, its grant and slot free are all high.
REQ-015 a_ready SHALL equal grant_a && slot free; b_ready SHALL equal grant_b && slot free; a_ready and b_ready SHALL never both be high.
REQ-016 Grant SHALL be combinational from current valids and state: only A valid -> A; only B valid -> B; both valid -> the source not granted on the last transfer (round-robin).
REQ-017 Latency SHALL be 1 cycle: a beat accepted in cycle n SHALL appear on y_data/y_last/sel with y_valid high in cycle n+1.
REQ-018 y_valid SHALL stay high and y_data/y_last/sel SHALL stay stable until y_ready is high.
REQ-019 With slot occupied and y_ready high, a new accept and the drain SHALL occur in the same cycle, giving full throughput (one beat per cycle).
REQ-020 With y_ready high and no input valid, y_valid SHALL fall in the next cycle.
REQ-021 last_grant SHALL update only on a transfer; equal A/B load SHALL alternate A,B,A,B.
REQ-022 State machine SHALL have states IDLE, HOLD_A and HOLD_B; without the configured feature it SHALL remain in IDLE.

Reset
REQ-023 On reset, y_valid, y_last and sel SHALL be 0, y_data SHALL be all zeros, state SHALL be IDLE, and last_grant SHALL be B, so A wins the first contention.
REQ-024 Reset asserted mid-packet or mid-stall SHALL discard the held beat immediately, with no glitch on y_valid after deassertion.

Configuration
REQ-025 Macro MUX2_ARB_PACKET_LOCK_EN defined: on accepting a non-last beat from A (B), state SHALL go to HOLD_A (HOLD_B).
REQ-026 In HOLD_A (HOLD_B) grant SHALL stay on that source regardless of the other valid, even while the held source's valid is low.
REQ-027 Acceptance of the beat with last = 1 SHALL return state to IDLE; a single-beat packet (last = 1 on the first beat) SHALL not leave IDLE.
REQ-028 Macro undefined: a_last/b_last SHALL only pass through to y_last; arbitration SHALL be per beat.

Structure
REQ-029 A shared package mux2_arb_pkg SHALL hold the state enum (IDLE, HOLD_A, HOLD_B), the select constants SEL_A = 0 and SEL_B = 1, and the WIDTH default.
REQ-030 Sub-module rr_grant2 (combinational two-request round-robin grant from valids and last_grant) SHALL be instantiated once; the FSM and output register SHALL live in mux2_arbiter.

Verification
REQ-031 Reset then a_valid = 1, a_data = 0x11, y_ready = 1 -> a_ready = 1 in cycle 0; y_valid = 1, y_data = 0x11, sel = 0 in cycle 1.
REQ-032 Both valid continuously, A = 0xA0.., B = 0xB0.., y_ready = 1 -> output order A0, B0, A1, B1, with no bubble cycles.
REQ-033 y_valid = 1 with y_data = 0x5C, y_ready = 0 for 4 cycles, both valid -> y_data holds 0x5C and a_ready = b_ready = 0 throughout.
REQ-034 MUX2_ARB_PACKET_LOCK_EN defined, A sends 3 beats (last on beat 3) while B is valid -> three A beats are emitted before any B beat; without the macro the beats interleave A, B, A.
REQ-035 Reset pulsed while y_valid = 1 and state = HOLD_B -> y_valid = 0, state = IDLE, and after release A wins the first contention.
